sdram_word_responder: RTL and testbench

Avalon-MM memory-mapped responder that stands in for the SDRAM controller on the word-copy accelerator's master port. It accepts single-word reads and writes against an internal word array. It inserts a programmable number of wait states per command through `slave_waitrequest`, and returns read data through a fixed-latency `slave_readdatavalid` pipeline. It is the target-side counterpart to the copy engine's master FSM, and it gives that master a deterministic, self-checking memory to run against in simulation and on-chip.

---
 rtl/sdram_word_responder_if.sv | 31 +++
 rtl/sdram_word_responder.sv | 125 ++++++++++++
 tb/tb_sdram_word_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_word_responder_if.sv
// Avalon-MM bus between the copy engine's master port and the SDRAM stand-in responder.
// The master drives the command; the responder drives waitrequest and the read response.
interface sdram_word_responder_if;
  logic [31:0] slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_waitrequest;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;

  modport master (
    output slave_address,
    output slave_read,
    output slave_write,
    output slave_writedata,
    input  slave_waitrequest,
    input  slave_readdata,
    input  slave_readdatavalid
  );

  modport slave (
    input  slave_address,
    input  slave_read,
    input  slave_write,
    input  slave_writedata,
    output slave_waitrequest,
    output slave_readdata,
    output slave_readdatavalid
  );
endinterface

// File: rtl/sdram_word_responder.sv
// Word-array memory that answers single-word Avalon-MM reads/writes with programmable wait
// states, a fixed-latency readdatavalid pipeline, a sticky error flag and saturating counters.
module sdram_word_responder #(
  parameter int ADDR_W       = 17,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_word_responder_if.slave bus,
  output logic                 err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam logic [3:0]  WaitVal   = 4'(WAIT_CYCLES);
  localparam logic [31:0] OorPatten = 32'hDEADBEEF;

  logic [31:0] mem [2**ADDR_W];

  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        err_q, err_d;
  logic [15:0] rdCount_q, rdCount_d;
  logic [15:0] wrCount_q, wrCount_d;
  logic        rdVld_q [READ_LATENCY];
  logic [31:0] rdDat_q [READ_LATENCY];

  logic              cmd;
  logic              waitReq;
  logic              accept;
  logic              bothCmd;
  logic              misaligned;
  logic              outOfRange;
  logic              doRead;
  logic              doWrite;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       readWord;

  assign cmd        = bus.slave_read | bus.slave_write;
  assign waitReq    = cmd && (waitCnt_q != WaitVal);
  assign accept     = cmd && !waitReq && !reset;
  assign bothCmd    = bus.slave_read & bus.slave_write;
  assign misaligned = |bus.slave_address[1:0];
  assign outOfRange = |bus.slave_address[31:ADDR_W+2];
  assign wordIdx    = bus.slave_address[ADDR_W+1:2];

  // A read+write collision is accepted but touches neither the array nor the counters.
  assign doRead  = accept && bus.slave_read  && !bus.slave_write;
  assign doWrite = accept && bus.slave_write && !bus.slave_read && !outOfRange;

  assign readWord = outOfRange ? OorPatten : mem[wordIdx];

  always_comb begin
    waitCnt_d = waitCnt_q;
    err_d     = err_q;
    rdCount_d = rdCount_q;
    wrCount_d = wrCount_q;

    if (accept) begin
      waitCnt_d = 4'd0;
    end else if (cmd) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end

    if (accept && (bothCmd || misaligned || outOfRange)) begin
      err_d = 1'b1;
    end

    if (doRead && (rdCount_q != 16'hFFFF)) begin
      rdCount_d = rdCount_q + 16'd1;
    end

    // Out-of-range writes are still accepted writes even though the array is left alone.
    if (accept && bus.slave_write && !bus.slave_read && (wrCount_q != 16'hFFFF)) begin
      wrCount_d = wrCount_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      waitCnt_q <= 4'd0;
      err_q     <= 1'b0;
      rdCount_q <= 16'd0;
      wrCount_q <= 16'd0;
    end else begin
      waitCnt_q <= waitCnt_d;
      err_q     <= err_d;
      rdCount_q <= rdCount_d;
      wrCount_q <= wrCount_d;
    end
  end

  always_ff @(posedge clock) begin
    if (doWrite) begin
      mem[wordIdx] <= bus.slave_writedata;
    end
  end

  // Stage 0 captures at the accept edge; the last stage is the visible response.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rdVld_q[i] <= 1'b0;
        rdDat_q[i] <= 32'd0;
      end
    end else begin
      rdVld_q[0] <= doRead;
      if (doRead) begin
        rdDat_q[0] <= readWord;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        rdVld_q[i] <= rdVld_q[i-1];
        rdDat_q[i] <= rdDat_q[i-1];
      end
    end
  end

  assign bus.slave_waitrequest   = waitReq;
  assign bus.slave_readdatavalid = rdVld_q[READ_LATENCY-1];
  assign bus.slave_readdata      = rdDat_q[READ_LATENCY-1];
  assign err                     = err_q;
  assign rd_count                = rdCount_q;
  assign wr_count                = wrCount_q;

endmodule

// File: tb/tb_sdram_word_responder.sv
// Bench for sdram_word_responder: three instances with different wait/latency settings,
// a vector table, hand-written corner sequences and a randomized run against a word model.
module tb_sdram_word_responder;

  localparam int AW = 17;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    logic [15:0] expRd;
    logic [15:0] expWr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic        monEn = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  resp_t       expQ[$];
  logic [31:0] mMem [int];
  int          mRd;
  int          mWr;
  logic        mErr;

  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  sdram_word_responder_if busA ();
  sdram_word_responder_if busB ();
  sdram_word_responder_if busC ();

  assign busA.slave_address   = addr;
  assign busA.slave_writedata = wdata;
  assign busA.slave_read      = rd & (sel == 2'd0);
  assign busA.slave_write     = wr & (sel == 2'd0);
  assign busB.slave_address   = addr;
  assign busB.slave_writedata = wdata;
  assign busB.slave_read      = rd & (sel == 2'd1);
  assign busB.slave_write     = wr & (sel == 2'd1);
  assign busC.slave_address   = addr;
  assign busC.slave_writedata = wdata;
  assign busC.slave_read      = rd & (sel == 2'd2);
  assign busC.slave_write     = wr & (sel == 2'd2);

  logic        errA, errB, errC;
  logic [15:0] rdA, rdB, rdC, wrA, wrB, wrC;

  sdram_word_responder #(.ADDR_W(AW), .WAIT_CYCLES(1), .READ_LATENCY(2)) dutA (
    .clock(clk), .reset(rst), .bus(busA), .err(errA), .rd_count(rdA), .wr_count(wrA));
  sdram_word_responder #(.ADDR_W(AW), .WAIT_CYCLES(0), .READ_LATENCY(3)) dutB (
    .clock(clk), .reset(rst), .bus(busB), .err(errB), .rd_count(rdB), .wr_count(wrB));
  sdram_word_responder #(.ADDR_W(AW), .WAIT_CYCLES(2), .READ_LATENCY(4)) dutC (
    .clock(clk), .reset(rst), .bus(busC), .err(errC), .rd_count(rdC), .wr_count(wrC));

  logic        curWait, curValid, curErr;
  logic [31:0] curData;
  logic [15:0] curRd, curWr;

  always_comb begin
    curWait  = busA.slave_waitrequest;
    curValid = busA.slave_readdatavalid;
    curData  = busA.slave_readdata;
    curErr   = errA;
    curRd    = rdA;
    curWr    = wrA;
    case (sel)
      2'd1: begin
        curWait = busB.slave_waitrequest; curValid = busB.slave_readdatavalid;
        curData = busB.slave_readdata;    curErr = errB; curRd = rdB; curWr = wrB;
      end
      2'd2: begin
        curWait = busC.slave_waitrequest; curValid = busC.slave_readdatavalid;
        curData = busC.slave_readdata;    curErr = errC; curRd = rdC; curWr = wrC;
      end
      default: ;
    endcase
  end

  function automatic int waitOf(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 0 : 2;
  endfunction

  function automatic int latOf(input logic [1:0] s);
    return (s == 2'd0) ? 2 : (s == 2'd1) ? 3 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Every readdatavalid pulse must match the oldest outstanding expectation, on its due cycle.
  always @(negedge clk) begin
    resp_t r;
    if (monEn) begin
      if (curValid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rdv_unexpected actual=1 expected=0 data=%h cycle=%0d", curData, cyc);
        end else begin
          r = expQ.pop_front();
          check("rdv_data", curData, r.data);
          check("rdv_cycle", cyc, r.due);
        end
      end else if (expQ.size() != 0 && expQ[0].due < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL rdv_missing actual=0 expected=1 due=%0d cycle=%0d", expQ[0].due, cyc);
        expQ.delete(0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accept edge with the command removed.
  task automatic doCmd(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                       input int expStalls, output int acc);
    int stalls;
    bit accepted;
    stalls   = 0;
    accepted = 1'b0;
    acc      = -1;
    addr = a; rd = r; wr = w; wdata = d;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (curWait) stalls++;
      else begin
        accepted = 1'b1;
        acc = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    wr = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=stalled expected=accepted addr=%h", a);
    end
    check("stall_cycles", stalls, expStalls);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    mRd  = 0;
    mWr  = 0;
    mErr = 1'b0;
  endtask

  // Reference behaviour of one accepted command, in terms of words, counts and the error flag.
  task automatic modelOp(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                         input int acc);
    int idx;
    bit oor;
    idx = int'(a[AW+1:2]);
    oor = (a >> (AW + 2)) != 0;
    if (r && w) begin
      mErr = 1'b1;
    end else begin
      if (a[1:0] != 2'd0 || oor) mErr = 1'b1;
      if (w) begin
        if (!oor) mMem[idx] = d;
        if (mWr < 65535) mWr++;
      end
      if (r) begin
        expQ.push_back('{oor ? 32'hDEADBEEF : mMem[idx], acc + latOf(sel) - 1});
        if (mRd < 65535) mRd++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[7];
    int          acc, acc1, acc2, acc3;
    logic [31:0] a, d;
    logic        r, w;

    vecs[0] = '{32'd400000, 1'b0, 1'b1, 32'd100,       32'd0,         1'b0, 16'd0, 16'd1};
    vecs[1] = '{32'd400000, 1'b1, 1'b0, 32'd0,         32'd100,       1'b0, 16'd1, 16'd1};
    vecs[2] = '{32'h0,      1'b0, 1'b1, 32'h11111111,  32'd0,         1'b0, 16'd1, 16'd2};
    vecs[3] = '{32'h8,      1'b0, 1'b1, 32'hCAFE0008,  32'd0,         1'b0, 16'd1, 16'd3};
    vecs[4] = '{32'hA,      1'b1, 1'b0, 32'd0,         32'hCAFE0008,  1'b1, 16'd2, 16'd3};
    vecs[5] = '{32'h20,     1'b0, 1'b1, 32'd7,         32'd0,         1'b1, 16'd2, 16'd4};
    vecs[6] = '{32'h20,     1'b1, 1'b0, 32'd0,         32'd7,         1'b1, 16'd3, 16'd4};

    sel = 2'd0; addr = 32'd0; wdata = 32'd0; wr = 1'b0; rd = 1'b1; rst = 1'b1;
    mRd = 0; mWr = 0; mErr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", curValid, 1'b0);
    check("rst_rdcount", curRd, 16'd0);
    check("rst_err", curErr, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd = 1'b0;
    monEn = 1'b1;
    idle(3);
    check("rst_no_accept", curRd, 16'd0);

    for (int i = 0; i < 7; i++) begin
      doCmd(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, 1, acc);
      if (vecs[i].rd) expQ.push_back('{vecs[i].expData, acc + 1});
      idle(4);
      check("vec_err", curErr, vecs[i].expErr);
      check("vec_rdcount", curRd, vecs[i].expRd);
      check("vec_wrcount", curWr, vecs[i].expWr);
      check("vec_drain", expQ.size(), 0);
    end

    applyReset();
    doCmd(32'h00100000, 1'b1, 1'b0, 32'd0, 1, acc);
    expQ.push_back('{32'hDEADBEEF, acc + 1});
    idle(4);
    check("oor_read_err", curErr, 1'b1);
    check("oor_read_drain", expQ.size(), 0);

    applyReset();
    doCmd(32'h00100000, 1'b0, 1'b1, 32'h12345678, 1, acc);
    idle(2);
    check("oor_write_err", curErr, 1'b1);
    doCmd(32'h0, 1'b1, 1'b0, 32'd0, 1, acc);
    expQ.push_back('{32'h11111111, acc + 1});
    idle(4);
    check("oor_write_drain", expQ.size(), 0);

    sel = 2'd1;
    applyReset();
    doCmd(32'h10, 1'b0, 1'b1, 32'd1, 0, acc);
    doCmd(32'h14, 1'b0, 1'b1, 32'd2, 0, acc);
    doCmd(32'h18, 1'b0, 1'b1, 32'd3, 0, acc);
    doCmd(32'h10, 1'b1, 1'b0, 32'd0, 0, acc1);
    expQ.push_back('{32'd1, acc1 + 2});
    doCmd(32'h14, 1'b1, 1'b0, 32'd0, 0, acc2);
    expQ.push_back('{32'd2, acc2 + 2});
    doCmd(32'h18, 1'b1, 1'b0, 32'd0, 0, acc3);
    expQ.push_back('{32'd3, acc3 + 2});
    check("b2b_spacing1", acc2 - acc1, 1);
    check("b2b_spacing2", acc3 - acc2, 1);
    idle(6);
    check("b2b_drain", expQ.size(), 0);
    check("b2b_rdcount", curRd, 16'd3);

    sel = 2'd2;
    applyReset();
    addr = 32'h20;
    rd = 1'b1;
    @(negedge clk);
    check("chg_stall", curWait, 1'b1);
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(negedge clk);
    check("chg_idle_wait", curWait, 1'b0);
    @(posedge clk);
    #1;
    doCmd(32'h24, 1'b0, 1'b1, 32'd5, 1, acc);
    doCmd(32'h24, 1'b1, 1'b0, 32'd0, 2, acc);
    expQ.push_back('{32'd5, acc + 3});
    idle(6);
    check("chg_drain", expQ.size(), 0);
    check("chg_rdcount", curRd, 16'd1);
    check("chg_wrcount", curWr, 16'd1);
    check("chg_err", curErr, 1'b0);

    doCmd(32'h20, 1'b0, 1'b1, 32'd7, 2, acc);
    doCmd(32'h20, 1'b1, 1'b1, 32'h99, 2, acc);
    idle(7);
    check("both_err", curErr, 1'b1);
    check("both_rdcount", curRd, 16'd1);
    check("both_wrcount", curWr, 16'd2);
    doCmd(32'h20, 1'b1, 1'b0, 32'd0, 2, acc);
    expQ.push_back('{32'd7, acc + 3});
    idle(6);
    check("both_drain", expQ.size(), 0);

    applyReset();
    doCmd(32'h20, 1'b1, 1'b0, 32'd0, 2, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    idle(8);
    check("midrd_rdcount", curRd, 16'd0);
    check("midrd_err", curErr, 1'b0);

    for (int s = 0; s < 3; s += 2) begin
      sel = 2'(s);
      applyReset();
      mMem.delete();
      for (int k = 0; k < 16; k++) begin
        d = $urandom;
        a = 32'h4000 + 32'(k * 4);
        doCmd(a, 1'b0, 1'b1, d, waitOf(sel), acc);
        if (acc >= 0) modelOp(a, 1'b0, 1'b1, d, acc);
      end
      for (int n = 0; n < 150; n++) begin
        int kind;
        kind = $urandom_range(0, 7);
        r = (kind < 4) || (kind == 7);
        w = (kind >= 4);
        d = $urandom;
        a = 32'h4000 + 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        doCmd(a, r, w, d, waitOf(sel), acc);
        if (acc >= 0) modelOp(a, r, w, d, acc);
        check("rnd_err", curErr, mErr);
        check("rnd_rdcount", curRd, 16'(mRd));
        check("rnd_wrcount", curWr, 16'(mWr));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(latOf(sel) + 2);
      check("rnd_drain", expQ.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
